// File: rtl/color_palette_pkg.sv
// Shared types for the colour palette controller.
// Field-select codes and the key-repeat FSM state.
package color_palette_pkg;

  localparam logic [1:0] CH_R   = 2'd0;
  localparam logic [1:0] CH_G   = 2'd1;
  localparam logic [1:0] CH_B   = 2'd2;
  localparam logic [1:0] CH_ALL = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

endpackage

// File: rtl/color_palette_if.sv
// Key/select inputs and palette outputs of the
// colour palette controller.
interface color_palette_if #(
  parameter int NREG = 4,
  parameter int CW   = 8,
  parameter int SW   = $clog2(NREG)
);

  logic                 en;
  logic                 up;
  logic                 down;
  logic [SW-1:0]        sel;
  logic [1:0]           chan;
  logic [NREG*CW-1:0]   pal_out;
  logic                 changed;
  logic                 at_max;
  logic                 at_min;

  modport master (
    output en, up, down, sel, chan,
    input  pal_out, changed, at_max, at_min
  );

  modport slave (
    input  en, up, down, sel, chan,
    output pal_out, changed, at_max, at_min
  );

endinterface

// File: rtl/color_palette_ctrl_key_repeat.sv
// Press detection and DELAY/REPEAT auto-repeat timing;
// emits a step strobe and the direction of the hold.
module key_repeat
  import color_palette_pkg::*;
#(
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10
) (
  input  logic Clk,
  input  logic reset,
  input  logic en,
  input  logic up,
  input  logic down,
  input  logic ok,
  output logic press,
  output logic step,
  output logic idle,
  output logic dir
);

  localparam int MAXC =
    (REPEAT_DLY > REPEAT_RATE) ?
    REPEAT_DLY : REPEAT_RATE;
  localparam int CNTW = $clog2(MAXC + 1);
  localparam logic [CNTW-1:0] DLY_C =
    CNTW'(REPEAT_DLY);
  localparam logic [CNTW-1:0] RATE_C =
    CNTW'(REPEAT_RATE);
  localparam logic [CNTW-1:0] ONE =
    CNTW'(1);

  state_t          st;
  logic [CNTW-1:0] cnt;
  logic            dir_q;
  logic            armed;
  logic            hold;
  logic            due;

  assign idle = (st == IDLE);
  assign dir  = idle ? up : dir_q;

  assign hold = en & (dir_q ? (up & ~down)
                            : (down & ~up));

  // armed stays low after reset until both keys are seen released
  assign press = idle & armed & ok & en
               & (up ^ down);

  assign due = (st == DELAY) ? (cnt == DLY_C)
                             : (cnt == RATE_C);

  assign step = press | (~idle & hold & due);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      st    <= IDLE;
      cnt   <= '0;
      dir_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      if (!up && !down)
        armed <= 1'b1;
      unique case (st)
        IDLE: begin
          if (press) begin
            st    <= DELAY;
            cnt   <= ONE;
            dir_q <= up;
          end
        end
        DELAY, REPEAT: begin
          if (!hold) begin
            st  <= IDLE;
            cnt <= '0;
          end else if (due) begin
            st  <= REPEAT;
            cnt <= ONE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          st  <= IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/color_palette_ctrl.sv
// Palette register file with per-field step arithmetic
// and registered limit flags, driven by key_repeat.
module color_palette_ctrl
  import color_palette_pkg::*;
#(
  parameter int RW          = 3,
  parameter int GW          = 3,
  parameter int BW          = 2,
  parameter int NREG        = 4,
  parameter logic [NREG*(RW+GW+BW)-1:0] RST_PAL =
    32'h00FF00A4,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10,
  parameter int WRAP        = 0
) (
  input  logic           Clk,
  input  logic           reset,
  color_palette_if.slave bus
);

  localparam int CW = RW + GW + BW;
  localparam int SW = $clog2(NREG);
  localparam logic [SW:0] NLIM = (SW+1)'(NREG);
  localparam bit SAT = (WRAP == 0);

  logic               press;
  logic               step;
  logic               idle;
  logic               dir;
  logic               sel_ok;
  logic               tok;
  logic [SW-1:0]      sel_q;
  logic [SW-1:0]      tsel;
  logic [1:0]         chan_q;
  logic [1:0]         tchan;
  logic [NREG*CW-1:0] pal_q;
  logic [NREG*CW-1:0] pal_d;
  logic [CW-1:0]      ent;
  logic [CW-1:0]      ent_new;
  logic [RW-1:0]      r;
  logic [RW-1:0]      r_n;
  logic [GW-1:0]      g;
  logic [GW-1:0]      g_n;
  logic [BW-1:0]      b;
  logic [BW-1:0]      b_n;
  logic               ur;
  logic               ug;
  logic               ub;
  logic               mx_d;
  logic               mn_d;
  logic               changed_q;
  logic               at_max_q;
  logic               at_min_q;

  assign sel_ok = ({1'b0, bus.sel} < NLIM);

  key_repeat #(
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_key (
    .Clk   (Clk),
    .reset (reset),
    .en    (bus.en),
    .up    (bus.up),
    .down  (bus.down),
    .ok    (sel_ok),
    .press (press),
    .step  (step),
    .idle  (idle),
    .dir   (dir)
  );

  // live selection while idle, latched one during a hold
  assign tsel  = idle ? bus.sel  : sel_q;
  assign tchan = idle ? bus.chan : chan_q;
  assign tok   = idle ? sel_ok   : 1'b1;

  always_comb begin
    ent = '0;
    for (int k = 0; k < NREG; k++)
      if (tsel == SW'(k))
        ent = pal_q[k*CW +: CW];
  end

  assign r = ent[CW-1 -: RW];
  assign g = ent[GW+BW-1 -: GW];
  assign b = ent[BW-1:0];

  assign ur = step &
    (tchan == CH_R || tchan == CH_ALL);
  assign ug = step &
    (tchan == CH_G || tchan == CH_ALL);
  assign ub = step &
    (tchan == CH_B || tchan == CH_ALL);

  always_comb begin
    r_n = r;
    g_n = g;
    b_n = b;
    if (ur)
      r_n = dir ?
        ((SAT && &r)  ? r : r + RW'(1)) :
        ((SAT && ~|r) ? r : r - RW'(1));
    if (ug)
      g_n = dir ?
        ((SAT && &g)  ? g : g + GW'(1)) :
        ((SAT && ~|g) ? g : g - GW'(1));
    if (ub)
      b_n = dir ?
        ((SAT && &b)  ? b : b + BW'(1)) :
        ((SAT && ~|b) ? b : b - BW'(1));
  end

  assign ent_new = {r_n, g_n, b_n};

  always_comb begin
    pal_d = pal_q;
    for (int k = 0; k < NREG; k++)
      if (step && tsel == SW'(k))
        pal_d[k*CW +: CW] = ent_new;
  end

  always_comb begin
    mx_d = 1'b0;
    mn_d = 1'b0;
    unique case (1'b1)
      (tchan == CH_R): begin
        mx_d = &r_n;
        mn_d = ~|r_n;
      end
      (tchan == CH_G): begin
        mx_d = &g_n;
        mn_d = ~|g_n;
      end
      (tchan == CH_B): begin
        mx_d = &b_n;
        mn_d = ~|b_n;
      end
      default: begin
        mx_d = &r_n & &g_n & &b_n;
        mn_d = ~|ent_new;
      end
    endcase
    if (!tok) begin
      mx_d = 1'b0;
      mn_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      pal_q     <= RST_PAL;
      sel_q     <= '0;
      chan_q    <= CH_R;
      changed_q <= 1'b0;
      at_max_q  <= 1'b0;
      at_min_q  <= 1'b0;
    end else begin
      pal_q     <= pal_d;
      changed_q <= step && (ent_new != ent);
      at_max_q  <= mx_d;
      at_min_q  <= mn_d;
      if (press) begin
        sel_q  <= bus.sel;
        chan_q <= bus.chan;
      end
    end
  end

  assign bus.pal_out = pal_q;
  assign bus.changed = changed_q;
  assign bus.at_max  = at_max_q;
  assign bus.at_min  = at_min_q;

endmodule

// File: tb/tb_color_palette_ctrl.sv
// Directed bench: a saturating and a wrapping instance
// driven with the same key sequences.
module tb_color_palette_ctrl;

  localparam int NREG = 4;
  localparam int CW   = 8;
  localparam logic [31:0] RST = 32'h00FF00A4;

  logic Clk   = 1'b0;
  logic reset = 1'b1;

  always #5 Clk = ~Clk;

  color_palette_if #(.NREG(NREG), .CW(CW)) bus ();
  color_palette_if #(.NREG(NREG), .CW(CW)) wbus ();

  assign wbus.en   = bus.en;
  assign wbus.up   = bus.up;
  assign wbus.down = bus.down;
  assign wbus.sel  = bus.sel;
  assign wbus.chan = bus.chan;

  color_palette_ctrl dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  color_palette_ctrl #(.WRAP(1)) dut_w (
    .Clk   (Clk),
    .reset (reset),
    .bus   (wbus)
  );

  typedef struct {
    logic [1:0] sel;
    logic [1:0] chan;
    logic       dir;
    int         hold;
    int         sw;
    logic [1:0] nsel;
    logic [1:0] nchan;
    logic [7:0] e;
    int         chg;
    logic       mx;
    logic       mn;
    logic [7:0] we;
  } vec_t;

  vec_t       tv [9];
  logic [7:0] em [4];
  logic [7:0] ew [4];
  int         checks;
  int         errors;
  int         chg;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (bus.changed === 1'b1)
      chg++;
  endtask

  function automatic logic [31:0] mpal();
    return {em[3], em[2], em[1], em[0]};
  endfunction

  function automatic logic [31:0] wpal();
    return {ew[3], ew[2], ew[1], ew[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      em[k] = RST[k*8 +: 8];
      ew[k] = RST[k*8 +: 8];
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    chg      = 0;
    bus.en   = 1'b1;
    bus.up   = 1'b0;
    bus.down = 1'b0;
    bus.sel  = 2'd0;
    bus.chan = 2'd0;
    model_reset();

    tv[0] = '{2'd0, 2'd0, 1'b1, 3,  0, 2'd0, 2'd0,
              8'hC4, 1, 1'b0, 1'b0, 8'hC4};
    tv[1] = '{2'd1, 2'd3, 1'b1, 75, 0, 2'd1, 2'd3,
              8'h93, 4, 1'b0, 1'b0, 8'h90};
    tv[2] = '{2'd2, 2'd0, 1'b1, 3,  0, 2'd2, 2'd0,
              8'hFF, 0, 1'b1, 1'b0, 8'h1F};
    tv[3] = '{2'd3, 2'd3, 1'b0, 3,  0, 2'd3, 2'd3,
              8'h00, 0, 1'b0, 1'b1, 8'hFF};
    tv[4] = '{2'd0, 2'd2, 1'b0, 3,  0, 2'd0, 2'd2,
              8'hC4, 0, 1'b0, 1'b1, 8'hC7};
    tv[5] = '{2'd0, 2'd1, 1'b0, 55, 0, 2'd0, 2'd1,
              8'hC0, 1, 1'b0, 1'b1, 8'hDF};
    tv[6] = '{2'd2, 2'd1, 1'b0, 61, 0, 2'd2, 2'd1,
              8'hF3, 3, 1'b0, 1'b0, 8'h13};
    tv[7] = '{2'd1, 2'd0, 1'b0, 60, 0, 2'd1, 2'd0,
              8'h53, 2, 1'b0, 1'b0, 8'h50};
    tv[8] = '{2'd3, 2'd0, 1'b1, 55, 10, 2'd2, 2'd2,
              8'h40, 2, 1'b1, 1'b0, 8'h3F};

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_pal",     bus.pal_out, RST);
    chk("rst_changed", {31'd0, bus.changed}, 0);
    chk("rst_at_max",  {31'd0, bus.at_max}, 0);
    chk("rst_at_min",  {31'd0, bus.at_min}, 0);
    chk("rst_wpal",    wbus.pal_out, RST);
    reset = 1'b0;
    repeat (2) tick();
    chk("post_rst_pal", bus.pal_out, RST);

    for (int i = 0; i < 9; i++) begin
      bus.sel  = tv[i].sel;
      bus.chan = tv[i].chan;
      bus.up   = tv[i].dir;
      bus.down = !tv[i].dir;
      chg      = 0;
      for (int c = 0; c < tv[i].hold; c++) begin
        tick();
        if (c + 1 == tv[i].sw) begin
          bus.sel  = tv[i].nsel;
          bus.chan = tv[i].nchan;
        end
      end
      bus.up   = 1'b0;
      bus.down = 1'b0;
      bus.sel  = tv[i].nsel;
      bus.chan = tv[i].nchan;
      repeat (3) tick();
      em[tv[i].sel] = tv[i].e;
      ew[tv[i].sel] = tv[i].we;
      $display("vector %0d", i);
      chk("vec_pal", bus.pal_out, mpal());
      chk("vec_changed", chg, tv[i].chg);
      chk("vec_at_max", {31'd0, bus.at_max},
          {31'd0, tv[i].mx});
      chk("vec_at_min", {31'd0, bus.at_min},
          {31'd0, tv[i].mn});
      chk("vec_wpal", wbus.pal_out, wpal());
    end

    // both keys together, then a disabled press
    bus.sel  = 2'd0;
    bus.chan = 2'd0;
    chg      = 0;
    bus.up   = 1'b1;
    bus.down = 1'b1;
    repeat (5) tick();
    bus.up   = 1'b0;
    bus.down = 1'b0;
    repeat (3) tick();
    chk("both_pal", bus.pal_out, mpal());
    chk("both_changed", chg, 0);
    bus.en = 1'b0;
    bus.up = 1'b1;
    repeat (5) tick();
    bus.up = 1'b0;
    bus.en = 1'b1;
    repeat (3) tick();
    chk("en0_pal", bus.pal_out, mpal());
    chk("en0_changed", chg, 0);

    // down rising during an up hold stops repeat
    bus.up = 1'b1;
    repeat (3) tick();
    bus.down = 1'b1;
    repeat (60) tick();
    bus.up   = 1'b0;
    bus.down = 1'b0;
    repeat (3) tick();
    em[0] = 8'hE0;
    ew[0] = 8'hFF;
    chk("abort_pal", bus.pal_out, mpal());
    chk("abort_changed", chg, 1);
    chk("abort_at_max", {31'd0, bus.at_max}, 1);
    chk("abort_wpal", wbus.pal_out, wpal());

    // reset in the middle of a hold
    chg    = 0;
    bus.up = 1'b1;
    repeat (20) tick();
    reset = 1'b1;
    #1;
    chk("midrst_pal", bus.pal_out, RST);
    repeat (2) tick();
    chk("midrst_at_max", {31'd0, bus.at_max}, 0);
    chk("midrst_at_min", {31'd0, bus.at_min}, 0);
    chk("midrst_changed", {31'd0, bus.changed}, 0);
    chk("midrst_wpal", wbus.pal_out, RST);
    reset = 1'b0;
    chg   = 0;
    repeat (10) tick();
    chk("held_pal", bus.pal_out, RST);
    chk("held_changed", chg, 0);
    bus.up = 1'b0;
    repeat (2) tick();
    bus.up = 1'b1;
    repeat (3) tick();
    bus.up = 1'b0;
    repeat (3) tick();
    model_reset();
    em[0] = 8'hC4;
    ew[0] = 8'hC4;
    chk("repress_pal", bus.pal_out, mpal());
    chk("repress_changed", chg, 1);
    chk("repress_wpal", wbus.pal_out, wpal());

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
